// File: rtl/muldiv_unit.sv
// Iterative RV64M/RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on magnitudes, a one-cycle sign fix, and early-out for div-by-zero/overflow.
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             word_op,
  input  logic [XLEN-1:0]  operand1,
  input  logic [XLEN-1:0]  operand2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic              word_q, neg_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] p_q;
  logic [TAG_W-1:0]  tag_q, tag_out_q;
  logic [XLEN-1:0]   result_q;

  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  logic            is_div, wd, s1, s2, sg1, sg2, neg, div0, ovf;
  logic [XLEN-1:0] x1, x2, m1, m2, spec_res, min_v;

  assign min_v = {1'b1, {(XLEN-1){1'b0}}};

  // Request decode: word ops are folded into XLEN-wide extended operands.
  always_comb begin
    is_div = op[2];
    wd     = (XLEN == 64) && word_op && (is_div || op == 3'b000);
    s1     = is_div ? !op[0] : (op == 3'b001 || op == 3'b010);
    s2     = is_div ? !op[0] : (op == 3'b001);
    x1     = wd ? (s1 ? sx32(operand1[31:0]) : XLEN'(operand1[31:0])) : operand1;
    x2     = wd ? (s2 ? sx32(operand2[31:0]) : XLEN'(operand2[31:0])) : operand2;
    sg1    = s1 && x1[XLEN-1];
    sg2    = s2 && x2[XLEN-1];
    m1     = sg1 ? -x1 : x1;
    m2     = sg2 ? -x2 : x2;
    neg    = (is_div && op[1]) ? sg1 : (sg1 ^ sg2);
    div0   = is_div && (x2 == '0);
    ovf    = is_div && !op[0] && (x1 == (wd ? sx32(32'h8000_0000) : min_v)) && (x2 == '1);
    spec_res = '1;
    if (div0)     spec_res = op[1] ? (wd ? sx32(operand1[31:0]) : operand1) : '1;
    else if (ovf) spec_res = op[1] ? '0 : x1;
  end

  logic [XLEN:0]     rsh, diff;
  logic              ge;
  logic [2*XLEN-1:0] p_d, full;
  logic [XLEN-1:0]   b_d, dv, dvn, fix_res;

  // b_q is consumed MSB-first; for divide the quotient bits shift in at its LSB.
  always_comb begin
    rsh  = {p_q[XLEN-1:0], b_q[XLEN-1]};
    diff = rsh - {1'b0, a_q};
    ge   = !diff[XLEN];
    if (op_q[2]) begin
      p_d = {{XLEN{1'b0}}, (ge ? diff[XLEN-1:0] : rsh[XLEN-1:0])};
      b_d = {b_q[XLEN-2:0], ge};
    end else begin
      p_d = {p_q[2*XLEN-2:0], 1'b0} + (b_q[XLEN-1] ? {{XLEN{1'b0}}, a_q} : '0);
      b_d = {b_q[XLEN-2:0], 1'b0};
    end
    full = neg_q ? -p_q : p_q;
    dv   = op_q[1] ? p_q[XLEN-1:0] : b_q;
    dvn  = neg_q ? -dv : dv;
    if (op_q[2])                fix_res = word_q ? sx32(dvn[31:0]) : dvn;
    else if (op_q[1:0] == 2'b00) fix_res = word_q ? sx32(full[31:0]) : full[XLEN-1:0];
    else                        fix_res = full[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      tag_q     <= '0;
      tag_out_q <= '0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q   <= op;
          word_q <= wd;
          neg_q  <= neg;
          tag_q  <= tag_in;
          a_q    <= op[2] ? m2 : m1;
          b_q    <= (op[2] ? m1 : m2) << (wd ? XLEN/2 : 0);
          p_q    <= '0;
          cnt_q  <= wd ? CW'(31) : CW'(XLEN-1);
          if (div0 || ovf) begin
            result_q  <= spec_res;
            tag_out_q <= tag_in;
            state_q   <= DONE;
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          p_q   <= p_d;
          b_q   <= b_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          result_q  <= fix_res;
          tag_out_q <= tag_q;
          state_q   <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign tag_out   = tag_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=64): vector table plus handshake, flush and reset sequences.
module tb_muldiv_unit;
  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             in_valid = 1'b0, word_op = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [2:0]       op = '0;
  logic [XLEN-1:0]  operand1 = '0, operand2 = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             in_ready, out_valid, busy;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .word_op(word_op), .operand1(operand1), .operand2(operand2), .tag_in(tag_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .tag_out(tag_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one request, scramble inputs while busy, wait for out_valid, then drain.
  task automatic run(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] t, output logic [63:0] res, output logic [4:0] tg,
                     output int lat);
    @(negedge clk);
    op = o; word_op = w; operand1 = a; operand2 = b; tag_in = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    operand1 = {$urandom, $urandom}; operand2 = {$urandom, $urandom};
    op = 3'($urandom); word_op = 1'($urandom); tag_in = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    res = result; tg = tag_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a, b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v[$];
    logic [63:0] r;
    logic [4:0]  tg;
    int          lat;
    logic        seen;

    v.push_back('{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66});
    v.push_back('{3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66});
    v.push_back('{3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 66});
    v.push_back('{3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66});
    v.push_back('{3'b100, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    v.push_back('{3'b111, 1'b0, 64'd100, 64'd0, 64'd100, 1});
    v.push_back('{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1});
    v.push_back('{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1});
    v.push_back('{3'b100, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 34});
    v.push_back('{3'b101, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 34});
    v.push_back('{3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34});
    v.push_back('{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66});
    v.push_back('{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66});
    v.push_back('{3'b000, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34});
    v.push_back('{3'b101, 1'b0, 64'd1000, 64'd7, 64'd142, 66});
    v.push_back('{3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1});
    v.push_back('{3'b011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66});
    v.push_back('{3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0, 1});

    // Reset state
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset result", result, 0);
    chk("reset tag_out", tag_out, 0);
    #20 rst_n = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      run(v[i].op, v[i].w, v[i].a, v[i].b, (i == 0) ? 5'd12 : 5'(i + 3), r, tg, lat);
      chk($sformatf("vec%0d result", i), r, v[i].exp);
      chk($sformatf("vec%0d latency", i), lat, v[i].lat);
      chk($sformatf("vec%0d tag", i), tg, (i == 0) ? 5'd12 : 5'(i + 3));
    end

    // Backpressure: result held stable while out_ready is low
    @(negedge clk);
    op = 3'b000; word_op = 1'b0; operand1 = 64'd3; operand2 = 64'd5; tag_in = 5'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; operand1 = 64'd99;
    lat = 1;
    while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    chk("bp out_valid", out_valid, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp result", result, 64'd15);
      chk("bp tag", tag_out, 5'd7);
      chk("bp out_valid hold", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp drain in_ready", in_ready, 1);
    chk("bp drain out_valid", out_valid, 0);

    // Flush beats a simultaneous accept
    @(negedge clk);
    op = 3'b101; operand1 = 64'd1000; operand2 = 64'd7; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush vs accept busy", busy, 0);

    // Flush on the 10th CALC cycle
    @(negedge clk);
    op = 3'b000; word_op = 1'b0; operand1 = 64'd11; operand2 = 64'd13; tag_in = 5'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre-flush busy", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush in_ready", in_ready, 1);
    chk("flush out_valid", out_valid, 0);
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("flushed result never valid", seen, 0);
    run(3'b101, 1'b0, 64'd1000, 64'd7, 5'd21, r, tg, lat);
    chk("post-flush DIVU result", r, 64'd142);
    chk("post-flush DIVU latency", lat, 66);
    chk("post-flush DIVU tag", tg, 5'd21);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    op = 3'b100; operand1 = 64'd500; operand2 = 64'd3; tag_in = 5'd30; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst in_ready", in_ready, 1);
    chk("async rst out_valid", out_valid, 0);
    chk("async rst result", result, 0);
    chk("async rst tag_out", tag_out, 0);
    #10 rst_n = 1'b1;
    run(3'b100, 1'b0, 64'd500, 64'd3, 5'd30, r, tg, lat);
    chk("post-reset DIV result", r, 64'd166);
    chk("post-reset DIV latency", lat, 66);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
